// File: rtl/kernel_launch_queue.sv
// Launch sequencer for the dispatch unit: queues per-kernel thread counts and
// runs them one at a time, with completion accounting and a RUN watchdog.
module kernel_launch_queue #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [7:0]               push_thread_count,
  output logic                     push_ready,
  output logic                     dispatch_reset,
  output logic                     dispatch_start,
  output logic [7:0]               dispatch_thread_count,
  input  logic                     dispatch_done,
  input  logic                     err_clear,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     busy,
  output logic                     kernel_done,
  output logic [7:0]               kernels_completed,
  output logic                     err_zero,
  output logic                     err_timeout
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CNT_W   = AW + 1;
  localparam logic [15:0]     WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, COMPLETE} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   wdog;

  logic push_accept;
  logic push_store;
  logic pop;
  logic run_done;
  logic run_timeout;

  // Readiness comes from the registered count only, so a full queue refuses a
  // push even on a cycle where an entry is being popped.
  assign push_ready  = (queue_count != CNT_W'(DEPTH));
  assign push_accept = push_valid && push_ready;
  assign push_store  = push_accept && (push_thread_count != 8'd0);
  assign pop         = ((state == IDLE) || (state == COMPLETE)) && (queue_count != '0);
  assign run_done    = (state == RUN) && dispatch_done;
  assign run_timeout = (state == RUN) && !dispatch_done &&
                       (TIMEOUT_CYCLES != 0) && (wdog == WD_LAST);
  assign busy        = (state != IDLE) || (queue_count != '0);

  // NOTE: storage has no reset; an entry is only read after the count says it
  // was written, so clearing it would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_store) mem[wr_ptr] <= push_thread_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push_store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      case ({push_store, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      dispatch_reset        <= 1'b1;
      dispatch_start        <= 1'b0;
      dispatch_thread_count <= 8'd0;
      wdog                  <= '0;
      kernel_done           <= 1'b0;
      kernels_completed     <= 8'd0;
      err_zero              <= 1'b0;
      err_timeout           <= 1'b0;
    end else begin
      kernel_done <= 1'b0;
      case (state)
        IDLE, COMPLETE: begin
          if (pop) begin
            dispatch_thread_count <= mem[rd_ptr];
            state                 <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          state          <= RUN;
          wdog           <= '0;
          dispatch_reset <= 1'b0;
          dispatch_start <= 1'b1;
        end
        RUN: begin
          wdog <= wdog + 16'd1;
          if (run_done || run_timeout) begin
            state          <= COMPLETE;
            dispatch_reset <= 1'b1;
            dispatch_start <= 1'b0;
          end
          if (run_done) begin
            kernel_done       <= 1'b1;
            kernels_completed <= kernels_completed + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // A new error event wins over a simultaneous clear.
      if (push_accept && (push_thread_count == 8'd0)) err_zero <= 1'b1;
      else if (err_clear)                              err_zero <= 1'b0;
      if (run_timeout)    err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kernel_launch_queue.sv
// Randomized bench for kernel_launch_queue: one instance without and one with
// an 8-cycle watchdog, both checked every cycle against a queue-based model.
module tb_kernel_launch_queue;

  localparam int DEPTH = 4;

  typedef enum {P_IDLE, P_LOAD, P_RUN, P_DONE} phase_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_valid;
  logic [7:0] push_thread_count;
  logic       dispatch_done;
  logic       err_clear;

  logic       a_push_ready, a_dispatch_reset, a_dispatch_start, a_busy, a_kernel_done;
  logic       a_err_zero, a_err_timeout;
  logic [7:0] a_dispatch_thread_count, a_kernels_completed;
  logic [2:0] a_queue_count;
  logic       b_push_ready, b_dispatch_reset, b_dispatch_start, b_busy, b_kernel_done;
  logic       b_err_zero, b_err_timeout;
  logic [7:0] b_dispatch_thread_count, b_kernels_completed;
  logic [2:0] b_queue_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kernel_launch_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_thread_count(push_thread_count),
    .push_ready(a_push_ready), .dispatch_reset(a_dispatch_reset), .dispatch_start(a_dispatch_start),
    .dispatch_thread_count(a_dispatch_thread_count), .dispatch_done(dispatch_done),
    .err_clear(err_clear), .queue_count(a_queue_count), .busy(a_busy),
    .kernel_done(a_kernel_done), .kernels_completed(a_kernels_completed),
    .err_zero(a_err_zero), .err_timeout(a_err_timeout)
  );

  kernel_launch_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_thread_count(push_thread_count),
    .push_ready(b_push_ready), .dispatch_reset(b_dispatch_reset), .dispatch_start(b_dispatch_start),
    .dispatch_thread_count(b_dispatch_thread_count), .dispatch_done(dispatch_done),
    .err_clear(err_clear), .queue_count(b_queue_count), .busy(b_busy),
    .kernel_done(b_kernel_done), .kernels_completed(b_kernels_completed),
    .err_zero(b_err_zero), .err_timeout(b_err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: launch queue as a plain queue, one per instance.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  phase_t     m_ph[2];
  int         m_run[2];
  logic [7:0] m_tc[2];
  logic       m_kd[2];
  logic [7:0] m_kc[2];
  logic       m_ez[2];
  logic       m_et[2];

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] qpop(input int i);
    return (i == 0) ? mq0.pop_front() : mq1.pop_front();
  endfunction

  function automatic void qpush(input int i, input logic [7:0] v);
    if (i == 0) mq0.push_back(v);
    else        mq1.push_back(v);
  endfunction

  task automatic model_step(input int i, input int tmo);
    int   cnt;
    logic acc, zev, nev, tev;
    if (reset) begin
      if (i == 0) mq0.delete();
      else        mq1.delete();
      m_ph[i] = P_IDLE; m_run[i] = 0; m_tc[i] = 8'd0; m_kd[i] = 1'b0;
      m_kc[i] = 8'd0;   m_ez[i] = 1'b0; m_et[i] = 1'b0;
      return;
    end
    cnt = qsize(i);
    acc = push_valid && (cnt < DEPTH);
    zev = acc && (push_thread_count == 8'd0);
    nev = (m_ph[i] == P_RUN) && dispatch_done;
    tev = (m_ph[i] == P_RUN) && !dispatch_done && (tmo != 0) && (m_run[i] == tmo);
    m_kd[i] = nev;
    if (nev) m_kc[i] = m_kc[i] + 8'd1;
    m_ez[i] = zev ? 1'b1 : (err_clear ? 1'b0 : m_ez[i]);
    m_et[i] = tev ? 1'b1 : (err_clear ? 1'b0 : m_et[i]);
    case (m_ph[i])
      P_IDLE, P_DONE: begin
        if (cnt != 0) begin
          m_tc[i] = qpop(i);
          m_ph[i] = P_LOAD;
        end else begin
          m_ph[i] = P_IDLE;
        end
      end
      P_LOAD: begin m_ph[i] = P_RUN; m_run[i] = 1; end
      default: begin
        if (nev || tev) m_ph[i] = P_DONE;
        else            m_run[i]++;
      end
    endcase
    if (acc && (push_thread_count != 8'd0)) qpush(i, push_thread_count);
  endtask

  task automatic compare_inst(input int i, input string nm,
                              input logic pr, input logic dr, input logic ds,
                              input logic [7:0] tc, input logic [2:0] qc,
                              input logic bsy, input logic kd, input logic [7:0] kc,
                              input logic ez, input logic et);
    int sz;
    sz = qsize(i);
    check({nm, ".push_ready"},            pr,  sz < DEPTH);
    check({nm, ".dispatch_reset"},        dr,  m_ph[i] != P_RUN);
    check({nm, ".dispatch_start"},        ds,  m_ph[i] == P_RUN);
    check({nm, ".dispatch_thread_count"}, tc,  m_tc[i]);
    check({nm, ".queue_count"},           qc,  sz);
    check({nm, ".busy"},                  bsy, (m_ph[i] != P_IDLE) || (sz != 0));
    check({nm, ".kernel_done"},           kd,  m_kd[i]);
    check({nm, ".kernels_completed"},     kc,  m_kc[i]);
    check({nm, ".err_zero"},              ez,  m_ez[i]);
    check({nm, ".err_timeout"},           et,  m_et[i]);
  endtask

  always @(posedge clk) begin
    model_step(0, 0);
    model_step(1, 8);
  end

  always @(negedge clk) begin
    compare_inst(0, "a", a_push_ready, a_dispatch_reset, a_dispatch_start, a_dispatch_thread_count,
                 a_queue_count, a_busy, a_kernel_done, a_kernels_completed, a_err_zero, a_err_timeout);
    compare_inst(1, "b", b_push_ready, b_dispatch_reset, b_dispatch_start, b_dispatch_thread_count,
                 b_queue_count, b_busy, b_kernel_done, b_kernels_completed, b_err_zero, b_err_timeout);
  end

  task automatic drive(input logic pv, input logic [7:0] ptc, input logic dn, input logic clr);
    @(negedge clk);
    push_valid        = pv;
    push_thread_count = ptc;
    dispatch_done     = dn;
    err_clear         = clr;
  endtask

  // Hold a push until instance a can take it (its readiness here is what the next edge sees).
  task automatic push_wait(input logic [7:0] v);
    int n;
    n = 0;
    drive(1'b1, v, 1'b0, 1'b0);
    while (!a_push_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_wait_bound", n < 100, 1'b1);
  endtask

  initial begin
    int starts;
    reset = 1'b1; push_valid = 1'b0; push_thread_count = 8'd0;
    dispatch_done = 1'b0; err_clear = 1'b0;
    m_ph = '{P_IDLE, P_IDLE}; m_run = '{0, 0}; m_tc = '{8'd0, 8'd0}; m_kd = '{1'b0, 1'b0};
    m_kc = '{8'd0, 8'd0}; m_ez = '{1'b0, 1'b0}; m_et = '{1'b0, 1'b0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset.a_push_ready", a_push_ready, 1'b1);
    check("reset.a_dispatch_reset", a_dispatch_reset, 1'b1);

    // Single launch of 10, done after 20 cycles.
    drive(1'b1, 8'd10, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("single.a_kernels_completed", a_kernels_completed, 8'd1);
    check("single.a_busy", a_busy, 1'b0);

    // Fill and overflow while RUN is stalled.
    for (int k = 0; k < 5; k++) push_wait(8'($urandom_range(1, 255)));
    drive(1'b1, 8'd77, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("fill.a_push_ready_held", a_push_ready, 1'b0);
    drive(1'b1, 8'd77, 1'b1, 1'b0);
    push_wait(8'd77);
    repeat (80) drive(1'b0, 8'd0, $urandom_range(0, 3) == 0, 1'b0);

    // Zero-thread push, then clear.
    drive(1'b1, 8'd0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("zero.a_err_zero", a_err_zero, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("zero.a_err_zero_cleared", a_err_zero, 1'b0);

    // Watchdog: two launches, done never asserted; instance b aborts each after 8 cycles.
    drive(1'b1, 8'd33, 1'b0, 1'b0);
    drive(1'b1, 8'd44, 1'b0, 1'b0);
    starts = 0;
    repeat (40) begin
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      if (b_dispatch_start) starts++;
    end
    check("wdog.b_start_cycles", starts, 16);
    check("wdog.b_err_timeout", b_err_timeout, 1'b1);
    repeat (20) drive(1'b0, 8'd0, $urandom_range(0, 2) == 0, 1'b1);

    // Reset in the middle of a run with launches queued; later done is ignored.
    for (int k = 0; k < 4; k++) drive(1'b1, 8'(k + 5), 1'b0, 1'b0);
    repeat (4) drive(1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midreset.a_queue_count", a_queue_count, 3'd0);
    repeat (3) drive(1'b0, 8'd0, 1'b1, 1'b0);
    check("midreset.a_kernels_completed", a_kernels_completed, 8'd0);

    // Random traffic, long enough for the completion counter to wrap.
    repeat (4000) begin
      @(negedge clk);
      reset             = ($urandom_range(0, 1499) == 0);
      push_valid        = ($urandom_range(0, 1) == 1);
      push_thread_count = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      dispatch_done     = ($urandom_range(0, 4) == 0);
      err_clear         = ($urandom_range(0, 19) == 0);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
